unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between two requesters: the fetch stage (PC/instruction port) and the MEM stage (data load/store port).
- Serialises accesses through a small FSM and returns one-cycle acknowledges.
- Drives per-stage stall signals so the pipeline registers hold while a request is outstanding.
- Sits between the pipeline (PC, BF2 outputs) and the shared memory macro.

Parameters:
IADDR_W, 8, fetch address width (PC width); zero-extended onto mem_addr
DATA_W, 32, data/instruction word width
MEM_LAT, 2, memory access cycles (>=1); mem_rdata valid in last access cycle
STARVE_MAX, 4, consecutive DM-over-IF wins before IF is forced through (>=1)

Ports:
clk_ARB  in  1  clock, rising edge
rstn_ARB  in  1  synchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  IADDR_W  fetch byte address
if_rdata  out  DATA_W  fetched instruction, valid with if_ack
if_ack  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1=store, 0=load
dm_addr  in  32  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid with dm_ack
dm_ack  out  1  one-cycle completion pulse for data
mem_en  out  1  memory enable, high for the whole access
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
stall_IF  out  1  if_req & ~if_ack
stall_MEM  out  1  dm_req & ~dm_ack

Behaviour:
- Reset (rstn_ARB low at an edge):
  - State goes to IDLE; latency counter and starve counter go to 0.
  - All registered outputs (if_rdata, dm_rdata, acks, mem_*) go to 0.
  - Reset is honoured mid-access: the access is abandoned and no ack is issued.
- States: IDLE, ACCESS, RESP.
- IDLE, arbitration:
  - If neither requester is active, stay in IDLE.
  - Only one requesting: grant it.
  - Both requesting: grant DM, unless starve_cnt == STARVE_MAX, in which case grant IF.
  - A DM grant while if_req is high increments starve_cnt (saturating at STARVE_MAX).
  - Any IF grant clears starve_cnt.
  - The grant latches owner, address (IF address zero-extended), we (forced 0 for IF) and wdata.
  - Next state: ACCESS, with cnt = MEM_LAT.
- ACCESS:
  - mem_en=1; mem_addr, mem_we and mem_wdata are driven from the latched values and stay stable.
  - cnt decrements each cycle.
  - When cnt==1, mem_rdata is captured into the owner's rdata register (load/fetch only; a store leaves dm_rdata unchanged), and the next state is RESP.
- RESP:
  - mem_en=0; the owner's ack=1 for exactly this cycle.
  - Next state is IDLE unconditionally.
- Timing:
  - Request granted at cycle t → access cycles t+1..t+MEM_LAT → ack at t+MEM_LAT+1.
  - The next arbitration happens at t+MEM_LAT+2.
  - Throughput: one access per MEM_LAT+2 cycles.
- Request inputs are sampled only at grant; changes to address or data while waiting before grant are taken, and changes after grant are ignored.
- If a requester drops req mid-access, the access completes and the ack still pulses; the requester ignores it.
- A req still high during its own ack cycle is not re-granted, because RESP always goes to IDLE. A new request must be presented in IDLE.
- Stalls are combinational from req and registered ack, so there is no cycle of stall after the ack.

Test Plan:
- Reset: start an IF access, pull rstn_ARB low for 2 cycles mid-ACCESS → mem_en=0, if_ack never pulses, all outputs 0; after release with no requests, mem_en stays 0.
- Lone fetch (MEM_LAT=2): if_req=1, if_addr=0x04 at t=0, memory returns 0x8C220004.
  - mem_en=1 and mem_addr=0x00000004 at t=1..2.
  - if_ack=1 and if_rdata=0x8C220004 at t=3.
  - stall_IF=1 at t=0..2 and 0 at t=3.
- Simultaneous requests at t=0 (IF 0x08, DM load 0x20) → DM access t=1..2, dm_ack at t=3, IF granted t=4, if_ack at t=7; stall_IF high t=0..6.
- Starvation (STARVE_MAX=4): if_req held high, DM re-requesting every IDLE → DM acked 4 times, 5th grant goes to IF, starve_cnt back to 0, then DM wins again.
- Store: dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF with dm_rdata previously 0x12345678.
  - mem_we=1, mem_addr=0x10 and mem_wdata=0xDEADBEEF for exactly 2 cycles.
  - dm_ack pulses once; dm_rdata stays 0x12345678.
- Drop mid-access: DM load granted, dm_req dropped at t=1 → mem_en is still high t=1..2, dm_ack pulses at t=3, FSM is in IDLE at t=4.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port, fixed-latency memory between the fetch stage (IF)
// and the data stage (DM). Grants are made only in IDLE. The winning request
// is latched and held on the mem_* bus for MEM_LAT cycles, then the owner gets
// a one-cycle ack. DM wins ties unless IF has lost STARVE_MAX ties in a row.
// Ports:
//   clk_ARB, rstn_ARB           clock, synchronous active-low reset
//   if_req/if_addr              fetch request (held until if_ack)
//   if_rdata/if_ack             fetched word, completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_ack)
//   dm_rdata/dm_ack             load data, completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  shared memory interface
//   stall_IF/stall_MEM          pipeline holds while a request is outstanding
module unified_mem_arbiter #(
  parameter int unsigned IADDR_W    = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk_ARB,
  input  logic               rstn_ARB,
  input  logic               if_req,
  input  logic [IADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0]  if_rdata,
  output logic               if_ack,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [31:0]        dm_addr,
  input  logic [DATA_W-1:0]  dm_wdata,
  output logic [DATA_W-1:0]  dm_rdata,
  output logic               dm_ack,
  output logic               mem_en,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               stall_IF,
  output logic               stall_MEM
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ST_W-1:0]     starve_q, starve_d;
  logic                owner_dm_q, owner_dm_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic                grant_dm;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    owner_dm_d  = owner_dm_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    grant_dm    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          // DM wins ties until IF has been passed over STARVE_MAX times.
          grant_dm = dm_req && !(if_req && (starve_q == ST_W'(STARVE_MAX)));
          if (grant_dm) begin
            owner_dm_d  = 1'b1;
            mem_addr_d  = dm_addr;
            mem_we_d    = dm_we;
            mem_wdata_d = dm_wdata;
            if (if_req && (starve_q != ST_W'(STARVE_MAX))) begin
              starve_d = starve_q + ST_W'(1);
            end
          end else begin
            owner_dm_d  = 1'b0;
            mem_addr_d  = '0;
            mem_addr_d[IADDR_W-1:0] = if_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
            starve_d    = '0;
          end
          mem_en_d = 1'b1;
          cnt_d    = CNT_W'(MEM_LAT);
          state_d  = ACCESS;
        end
      end

      ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Acks are registered, so raising them here makes them visible in RESP.
          if (owner_dm_q) begin
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_ack_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_ARB) begin
    if (!rstn_ARB) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      owner_dm_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_dm_q  <= owner_dm_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_IF  = if_req & ~if_ack_q;
  assign stall_MEM = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios followed by random
// request rounds, checked against a transaction-level model of arbitration,
// access timing and memory contents.
module tb_unified_mem_arbiter;

  localparam int unsigned IADDR_W    = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               if_req = 1'b0;
  logic [IADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0]  if_rdata;
  logic               if_ack;
  logic               dm_req = 1'b0;
  logic               dm_we = 1'b0;
  logic [31:0]        dm_addr = '0;
  logic [DATA_W-1:0]  dm_wdata = '0;
  logic [DATA_W-1:0]  dm_rdata;
  logic               dm_ack;
  logic               mem_en;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic               stall_IF;
  logic               stall_MEM;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // memory macro contents (environment) and the model's view of memory
  logic [31:0] resp_mem [256];
  logic [31:0] ref_mem  [256];
  int unsigned starve_m = 0;
  logic [31:0] exp_if = '0;
  logic [31:0] exp_dm = '0;
  bit          won_dm;

  always #5 clk = ~clk;

  assign mem_rdata = resp_mem[mem_addr[7:0]];

  unified_mem_arbiter #(
    .IADDR_W(IADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_ARB(clk), .rstn_ARB(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_IF(stall_IF), .stall_MEM(stall_MEM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // memory write happens at the edge using the bus values of the closing cycle
  task automatic tick();
    if (mem_en === 1'b1 && mem_we === 1'b1) resp_mem[mem_addr[7:0]] = mem_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_dm_ack"}, dm_ack, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_dm_rdata"}, dm_rdata, 0);
  endtask

  // One arbitration round starting in an IDLE cycle with inputs already set.
  task automatic run_round(input bit drop_mid, output bit g_dm);
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    #1;
    g_dm = 1'b0;
    chk("stall_IF_wait", stall_IF, if_req);
    chk("stall_MEM_wait", stall_MEM, dm_req);
    if (!(if_req || dm_req)) begin
      tick();
      chk("idle_mem_en", mem_en, 0);
      chk("idle_if_ack", if_ack, 0);
      chk("idle_dm_ack", dm_ack, 0);
      return;
    end
    if (if_req && dm_req) begin
      g_dm = (starve_m != STARVE_MAX);
      starve_m = g_dm ? starve_m + 1 : 0;
    end else begin
      g_dm = dm_req;
      if (!g_dm) starve_m = 0;
    end
    a  = g_dm ? dm_addr : {24'h0, if_addr};
    w  = g_dm & dm_we;
    wd = dm_wdata;
    if (!g_dm)   exp_if = ref_mem[a[7:0]];
    else if (!w) exp_dm = ref_mem[a[7:0]];
    else         ref_mem[a[7:0]] = wd;

    for (int unsigned k = 1; k <= MEM_LAT; k++) begin
      tick();
      if (k == 1) begin
        // post-grant changes from the owner must not reach the bus
        if (g_dm) begin dm_addr = $urandom; dm_wdata = $urandom; dm_we = ~dm_we; end
        else if_addr = IADDR_W'($urandom);
        if (drop_mid) begin
          if (g_dm) dm_req = 1'b0; else if_req = 1'b0;
        end
        #1;
      end
      chk("acc_mem_en", mem_en, 1);
      chk("acc_mem_addr", mem_addr, a);
      chk("acc_mem_we", mem_we, w);
      if (w) chk("acc_mem_wdata", mem_wdata, wd);
      chk("acc_if_ack", if_ack, 0);
      chk("acc_dm_ack", dm_ack, 0);
    end

    tick();
    chk("resp_if_ack", if_ack, !g_dm);
    chk("resp_dm_ack", dm_ack, g_dm);
    chk("resp_mem_en", mem_en, 0);
    chk("resp_mem_we", mem_we, 0);
    chk("resp_if_rdata", if_rdata, exp_if);
    chk("resp_dm_rdata", dm_rdata, exp_dm);
    chk("resp_stall_IF", stall_IF, if_req && g_dm);
    chk("resp_stall_MEM", stall_MEM, dm_req && !g_dm);
    if (g_dm) dm_req = 1'b0; else if_req = 1'b0;
    tick();  // IDLE again: next round starts here
  endtask

  initial begin
    for (int unsigned i = 0; i < 256; i++) begin
      resp_mem[i] = {8'(i), 8'(~i), 8'(i ^ 32'h5A), 8'hC3};
    end
    resp_mem[8'h04] = 32'h8C220004;
    resp_mem[8'h30] = 32'h12345678;
    for (int unsigned i = 0; i < 256; i++) ref_mem[i] = resp_mem[i];

    // power-on reset
    tick(); tick();
    chk_all_zero("por");
    rstn = 1'b1;
    tick();

    // reset in the middle of a fetch access
    if_req = 1'b1; if_addr = 8'h08;
    tick();
    chk("rst_pre_mem_en", mem_en, 1);
    rstn = 1'b0;
    tick();
    chk_all_zero("rst1");
    tick();
    chk_all_zero("rst2");
    rstn = 1'b1; if_req = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_mem_en", mem_en, 0);
      chk("post_rst_if_ack", if_ack, 0);
    end
    starve_m = 0; exp_if = '0; exp_dm = '0;

    // lone fetch from 0x04
    if_req = 1'b1; if_addr = 8'h04;
    run_round(1'b0, won_dm);
    chk("fetch_won", won_dm, 0);
    chk("fetch_rdata", if_rdata, 32'h8C220004);

    // simultaneous: DM first, IF right after
    if_req = 1'b1; if_addr = 8'h08;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    run_round(1'b0, won_dm);
    chk("simul_first_dm", won_dm, 1);
    run_round(1'b0, won_dm);
    chk("simul_second_if", won_dm, 0);

    // load 0x12345678, then store must leave dm_rdata alone
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
    run_round(1'b0, won_dm);
    chk("preload_dm_rdata", dm_rdata, 32'h12345678);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF;
    run_round(1'b0, won_dm);
    chk("store_keeps_rdata", dm_rdata, 32'h12345678);
    chk("store_landed", resp_mem[8'h10], 32'hDEADBEEF);

    // requester drops mid-access: access still completes and acks
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
    run_round(1'b1, won_dm);
    chk("drop_read_back", dm_rdata, 32'hDEADBEEF);
    run_round(1'b0, won_dm);  // nothing pending: IDLE, no access

    // starvation: four DM wins, then IF, then DM again
    for (int unsigned i = 0; i < 6; i++) begin
      if_req = 1'b1; if_addr = 8'(8'h40 + i);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80 + i;
      run_round(1'b0, won_dm);
      chk("starve_winner", won_dm, (i != 4));
    end
    if_req = 1'b0; dm_req = 1'b0;
    run_round(1'b0, won_dm);

    // random rounds; a pending (unserved) request keeps its fields
    for (int unsigned r = 0; r < 300; r++) begin
      if (!if_req && ($urandom_range(0, 1) == 1)) begin
        if_req = 1'b1; if_addr = IADDR_W'($urandom);
      end
      if (!dm_req && ($urandom_range(0, 1) == 1)) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      run_round($urandom_range(0, 7) == 0, won_dm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
